// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and helpers for the multiply/divide sequencer and its iterative divider.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;
    typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    // Oldest-first: lane 0 wins whenever it is pending.
    function automatic logic pick_lane(input logic [1:0] mask);
        return mask[0] ? 1'b0 : 1'b1;
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div.sv
// Radix-2 restoring unsigned 32/32 divider: first iteration on the start edge,
// done pulses for one cycle after the 32nd iteration.
module div_iter
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    logic [31:0]      rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [31:0]      src_rem, src_quo, src_dvs;
    logic [32:0]      shifted, diff;

    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    always_comb begin
        src_rem = start ? 32'd0 : rem_q;
        src_quo = start ? a : quo_q;
        src_dvs = start ? b : dvs_q;
        shifted = {src_rem, src_quo[31]};
        diff    = shifted - {1'b0, src_dvs};

        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start || busy_q) begin
            // Borrow out of the 33-bit trial subtraction means the divisor did not fit.
            if (diff[32]) begin
                rem_d = shifted[31:0];
                quo_d = {src_quo[30:0], 1'b0};
            end else begin
                rem_d = diff[31:0];
                quo_d = {src_quo[30:0], 1'b1};
            end
            dvs_d  = src_dvs;
            busy_d = 1'b1;
            cnt_d  = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
            if (!start && cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                cnt_d  = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign q    = quo_q;
    assign r    = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Arbiter/sequencer for the shared multiply/divide unit: serves requesting lanes
// oldest-first, stalls issue while busy and returns one tagged HI/LO result per request.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  muldiv_op_t  op0,
    input  muldiv_op_t  op1,
    input  logic [31:0] srca0,
    input  logic [31:0] srcb0,
    input  logic [31:0] srca1,
    input  logic [31:0] srcb1,
    input  logic        flush,
    output logic        stall,
    output logic        res_valid,
    output logic        res_lane,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [1:0]       served_q, served_d;
    logic             lane_q, lane_d;
    muldiv_op_t       op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [63:0]      pipe_q [MUL_LAT-1];

    logic        signed_op, sign_a, sign_b;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] mag_a, mag_b, div_q, div_r;
    logic        div_start, div_done;
    logic        complete, load;
    logic [1:0]  load_mask, remaining;
    logic [31:0] res_hi, res_lo;

    // Zero-extension for unsigned ops makes the low 64 bits of one multiplier correct for both.
    assign signed_op = op_is_signed(op_q);
    assign sign_a    = signed_op & a_q[31];
    assign sign_b    = signed_op & b_q[31];
    assign ext_a     = {{32{sign_a}}, a_q};
    assign ext_b     = {{32{sign_b}}, b_q};
    assign prod      = ext_a * ext_b;
    assign mag_a     = sign_a ? 32'd0 - a_q : a_q;
    assign mag_b     = sign_b ? 32'd0 - b_q : b_q;
    assign div_start = (state_q == DIV) && (counter_q == '0);

    div_iter u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .abort (flush),
        .a     (mag_a),
        .b     (mag_b),
        .done  (div_done),
        .q     (div_q),
        .r     (div_r)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        served_d  = served_q;
        lane_d    = lane_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        complete  = 1'b0;
        load      = 1'b0;
        load_mask = '0;
        remaining = '0;
        res_hi    = '0;
        res_lo    = '0;

        case (state_q)
            IDLE: begin
                load      = (req != 2'b00);
                load_mask = req;
            end
            MUL: begin
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == CNT_W'(MUL_LAT - 1)) begin
                    complete = 1'b1;
                    {res_hi, res_lo} = pipe_q[MUL_LAT-2];
                end
            end
            DIV: begin
                counter_d = counter_q + CNT_W'(1);
                if (div_done) begin
                    complete = 1'b1;
                    if (b_q == 32'd0) begin
                        res_hi = a_q;
                        res_lo = 32'hFFFF_FFFF;
                    end else begin
                        res_lo = (sign_a ^ sign_b) ? 32'd0 - div_q : div_q;
                        res_hi = sign_a ? 32'd0 - div_r : div_r;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            served_d  = served_q | (lane_q ? 2'b10 : 2'b01);
            remaining = req & ~served_d;
            if (remaining != 2'b00) begin
                load      = 1'b1;
                load_mask = remaining;
            end else begin
                state_d  = IDLE;
                served_d = '0;
            end
        end

        if (load) begin
            lane_d    = pick_lane(load_mask);
            op_d      = lane_d ? op1 : op0;
            a_d       = lane_d ? srca1 : srca0;
            b_d       = lane_d ? srcb1 : srcb0;
            counter_d = '0;
            state_d   = op_is_div(op_d) ? DIV : MUL;
        end

        // Abort outranks a same-cycle completion: the result is dropped.
        if (flush) begin
            state_d   = IDLE;
            served_d  = '0;
            counter_d = '0;
            complete  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            served_q  <= '0;
            lane_q    <= 1'b0;
            op_q      <= MD_MULT;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            served_q  <= served_d;
            lane_q    <= lane_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    // NOTE: pure datapath pipeline, no reset; its contents are only observed when the FSM says so.
    always_ff @(posedge clk) begin
        pipe_q[0] <= prod;
        for (int i = 1; i < MUL_LAT - 1; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign stall     = (req != 2'b00) && !(complete && remaining == 2'b00) && !flush && !reset;
    assign res_valid = complete;
    assign res_lane  = complete & lane_q;
    assign hi        = res_hi;
    assign lo        = res_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with MUL_LAT=3.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk, reset, flush;
    logic [1:0]  req;
    muldiv_op_t  op0, op1;
    logic [31:0] srca0, srcb0, srca1, srcb1;
    logic        stall, res_valid, res_lane;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_ctrl #(.MUL_LAT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op0       (op0),
        .op1       (op1),
        .srca0     (srca0),
        .srcb0     (srcb0),
        .srca1     (srca1),
        .srcb1     (srcb1),
        .flush     (flush),
        .stall     (stall),
        .res_valid (res_valid),
        .res_lane  (res_lane),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the current one until res_valid, noting any stall drop on the way.
    task automatic wait_res(input int limit, output int k, output bit stall_dropped);
        k = 0;
        stall_dropped = 1'b0;
        #1;
        while (!res_valid && k < limit) begin
            if (!stall) stall_dropped = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic drive(input logic [1:0] r, input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        req = r;
        op0 = o; srca0 = a; srcb0 = b;
        op1 = o; srca1 = a; srcb1 = b;
    endtask

    task automatic do_op(input string tag, input logic [1:0] r, input muldiv_op_t o,
                         input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                         input logic exp_lane, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int k;
        bit sd;
        drive(r, o, a, b);
        wait_res(60, k, sd);
        check({tag, " latency"}, 64'(k), 64'(exp_lat));
        check({tag, " stall held"}, 64'(sd), 64'(0));
        check({tag, " lane"}, 64'(res_lane), 64'(exp_lane));
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        check({tag, " stall at done"}, 64'(stall), 64'(0));
        step();
        req = 2'b00;
        step();
    endtask

    initial begin
        int  k;
        bit  sd;
        bit  early;

        reset = 1'b1; flush = 1'b0;
        drive(2'b00, MD_MULT, 32'd0, 32'd0);
        #1;
        check("rst stall", 64'(stall), 64'(0));
        check("rst res_valid", 64'(res_valid), 64'(0));
        check("rst res_lane", 64'(res_lane), 64'(0));
        check("rst hi", 64'(hi), 64'(0));
        check("rst lo", 64'(lo), 64'(0));
        req = 2'b01;
        #1;
        check("rst stall forced", 64'(stall), 64'(0));
        req = 2'b00;
        step();
        step();
        reset = 1'b0;
        step();

        do_op("mult", 2'b01, MD_MULT, 32'hFFFF_FFFD, 32'd5, 3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // Both lanes: lane 0 DIVU 100/7, lane 1 MULTU 0xFFFFFFFF*2.
        req = 2'b11;
        op0 = MD_DIVU;  srca0 = 32'd100;        srcb0 = 32'd7;
        op1 = MD_MULTU; srca1 = 32'hFFFF_FFFF;  srcb1 = 32'd2;
        wait_res(60, k, sd);
        check("dual0 latency", 64'(k), 64'(33));
        check("dual0 stall held", 64'(sd), 64'(0));
        check("dual0 lane", 64'(res_lane), 64'(0));
        check("dual0 lo", 64'(lo), 64'(14));
        check("dual0 hi", 64'(hi), 64'(2));
        check("dual0 stall stays", 64'(stall), 64'(1));
        step();
        wait_res(10, k, sd);
        check("dual1 latency", 64'(k), 64'(2));
        check("dual1 stall held", 64'(sd), 64'(0));
        check("dual1 lane", 64'(res_lane), 64'(1));
        check("dual1 hi", 64'(hi), 64'(1));
        check("dual1 lo", 64'(lo), 64'(32'hFFFF_FFFE));
        check("dual1 stall", 64'(stall), 64'(0));
        step();
        req = 2'b00;
        step();

        do_op("div neg", 2'b01, MD_DIV, 32'hFFFF_FFF9, 32'd2, 33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div ovf", 2'b01, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0, 32'd0, 32'h8000_0000);
        do_op("divu by0", 2'b01, MD_DIVU, 32'd5, 32'd0, 33, 1'b0, 32'd5, 32'hFFFF_FFFF);
        do_op("div by0 neg", 2'b01, MD_DIV, 32'hFFFF_FFF9, 32'd0, 33, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        do_op("lane1 multu", 2'b10, MD_MULTU, 32'h0001_0000, 32'h0001_0000, 3, 1'b1, 32'd1, 32'd0);

        // Flush ten cycles into a divide, then a fresh MULT right after.
        drive(2'b01, MD_DIV, 32'd100, 32'd7);
        early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (res_valid) early = 1'b1;
            step();
        end
        check("flush no early result", 64'(early), 64'(0));
        flush = 1'b1;
        #1;
        check("flush res_valid", 64'(res_valid), 64'(0));
        check("flush stall", 64'(stall), 64'(0));
        step();
        flush = 1'b0;
        do_op("post-flush mult", 2'b01, MD_MULT, 32'd7, 32'hFFFF_FFFE, 3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF2);

        // Reset in the final MUL cycle must suppress the pending result immediately.
        drive(2'b01, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1;
        check("pre-rst stall", 64'(stall), 64'(1));
        step();
        step();
        step();
        reset = 1'b1;
        req = 2'b00;
        #1;
        check("midop rst res_valid", 64'(res_valid), 64'(0));
        check("midop rst stall", 64'(stall), 64'(0));
        check("midop rst hi", 64'(hi), 64'(0));
        check("midop rst lo", 64'(lo), 64'(0));
        check("midop rst lane", 64'(res_lane), 64'(0));
        step();
        reset = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (res_valid) early = 1'b1;
            step();
        end
        check("post-rst quiet", 64'(early), 64'(0));
        do_op("post-rst mult", 2'b01, MD_MULT, 32'd3, 32'd4, 3, 1'b0, 32'd0, 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
